// File: rtl/mips_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_mdu_pkg
// Description : Shared definitions for the EX-stage multiply sequencer.
//               Provides the FSM state encoding, default datapath widths and
//               the ripple-adder helper functions (fa1bit, adder5bit).
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  // One-bit full adder; result is {carry_out, sum}.
  function automatic logic [1:0] fa1bit(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

  // Iteration-counter adder built from chained fa1bit; result is {carry_out, sum}.
  function automatic logic [MDU_CNT_W:0] adder5bit(input logic [MDU_CNT_W-1:0] a,
                                                   input logic [MDU_CNT_W-1:0] b,
                                                   input logic                 ci);
    logic                 c;
    logic [1:0]           r;
    logic [MDU_CNT_W-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < MDU_CNT_W; i++) begin
      r    = fa1bit(a[i], b[i], c);
      s[i] = r[0];
      c    = r[1];
    end
    return {c, s};
  endfunction

endpackage : mips_mdu_pkg
`default_nettype wire

// File: rtl/mult_acc_adder.sv
`default_nettype none
// ============================================================================
// Module      : mult_acc_adder
// Description : WIDTH-bit ripple adder (chained fa1bit) with carry-out, used
//               for the partial-product accumulate step of the multiplier.
// Ports       : a    [WIDTH-1:0] in  - accumulator operand
//               b    [WIDTH-1:0] in  - addend (multiplicand or zero)
//               sum  [WIDTH:0]   out - {carry_out, sum}
// Revision    : 1.0 - initial release
// ============================================================================
module mult_acc_adder
  import mips_mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  // Carry is threaded through a procedural variable rather than a vector so
  // the chain does not look like a combinational loop to analysis tools.
  always_comb begin : p_ripple
    logic       c;
    logic [1:0] r;
    c   = 1'b0;
    r   = '0;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r      = fa1bit(a[i], b[i], c);
      sum[i] = r[0];
      c      = r[1];
    end
    sum[WIDTH] = c;
  end

endmodule : mult_acc_adder
`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_ctrl
// Description : Iterative shift-add multiply sequencer for the EX stage.
//               Owns the HI/LO result registers, performs one add/shift per
//               cycle and stalls the pipeline while a product is pending.
// Config      : MULT_SIGNED_EN - adds signed_op port and the FIX state that
//               negates the 2*WIDTH product for signed operands of mixed sign.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               start, op_a, op_b   - issue multiply with operands
//               signed_op           - signed multiply (MULT_SIGNED_EN only)
//               rd_hilo             - EX instruction reads HI/LO
//               flush               - abort from branch/exception
//               busy, stall, done   - status; done is a one-cycle pulse
//               hi, lo              - registered product words
// Revision    : 1.0 - initial release
// ============================================================================
module mult_seq_ctrl
  import mips_mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             rd_hilo,
  input  logic             flush,
`ifdef MULT_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t       state, state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_sum;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mplr_nxt;
  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_b;
  logic             accept;
  logic             last_iter;

`ifdef MULT_SIGNED_EN
  logic               is_signed;
  logic               neg_res;
  logic [2*WIDTH-1:0] prod_neg;

  // Signed operands are reduced to magnitudes; the sign is restored in FIX.
  assign load_a   = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
  assign load_b   = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;
  assign prod_neg = -{hi, lo};
`else
  assign load_a = op_a;
  assign load_b = op_b;
`endif

  // A same-cycle flush cancels any start; starts while busy are ignored.
  assign accept = start && !flush && ((state == IDLE) || (state == DONE));

  // Counter increment; with WIDTH == 2**CNT_W the carry-out of cnt+1 marks
  // the final iteration (cnt == WIDTH-1).
  assign cnt_sum   = adder5bit(cnt, CNT_W'(1), 1'b0);
  assign last_iter = cnt_sum[CNT_W];

  // Accumulate step: the adder carry becomes the top bit before the shift.
  assign addend   = mplr[0] ? mcand : '0;
  assign acc_nxt  = sum[WIDTH:1];
  assign mplr_nxt = {sum[0], mplr[WIDTH-1:1]};

  mult_acc_adder #(
    .WIDTH (WIDTH)
  ) u_acc_adder (
    .a   (acc),
    .b   (addend),
    .sum (sum)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (last_iter) begin
`ifdef MULT_SIGNED_EN
          state_nxt = is_signed ? FIX : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
      FIX: begin
        state_nxt = flush ? IDLE : DONE;
      end
      DONE: begin
        state_nxt = accept ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = (state == RUN) || (state == FIX);
    done = (state == DONE);
  end

  assign stall = (rd_hilo || start) && busy;

  // --------------------------------------------------------------------------
  // Datapath: working registers and HI/LO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      acc       <= '0;
      mplr      <= '0;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
`ifdef MULT_SIGNED_EN
      is_signed <= 1'b0;
      neg_res   <= 1'b0;
`endif
    end else if (accept) begin
      mcand     <= load_a;
      acc       <= '0;
      mplr      <= load_b;
      cnt       <= '0;
`ifdef MULT_SIGNED_EN
      is_signed <= signed_op;
      neg_res   <= signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`endif
    end else if ((state == RUN) && !flush) begin
      acc  <= acc_nxt;
      mplr <= mplr_nxt;
      cnt  <= cnt_sum[CNT_W-1:0];
      // HI/LO change only when the product completes, so a flushed
      // operation leaves the previous result visible.
      if (last_iter) begin
        hi <= acc_nxt;
        lo <= mplr_nxt;
      end
    end
`ifdef MULT_SIGNED_EN
    else if ((state == FIX) && !flush && neg_res) begin
      {hi, lo} <= prod_neg;
    end
`endif
  end

endmodule : mult_seq_ctrl
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_seq_ctrl
// Description : Self-checking bench for mult_seq_ctrl. Products, latencies and
//               per-cycle busy/done/stall are predicted from plain arithmetic
//               and cycle counting. Build with MULT_SIGNED_EN to cover the
//               signed path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_seq_ctrl;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic        rd_hilo = 1'b0;
  logic        flush   = 1'b0;
  logic [31:0] op_a    = '0;
  logic [31:0] op_b    = '0;
`ifdef MULT_SIGNED_EN
  logic        signed_op = 1'b0;
`endif
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_hi  = '0;
  logic [31:0] exp_lo  = '0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(
    .WIDTH (32),
    .CNT_W (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_hilo   (rd_hilo),
    .flush     (flush),
`ifdef MULT_SIGNED_EN
    .signed_op (signed_op),
`endif
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one multiply at the current negedge and follow it cycle by cycle.
  // Cycle c is the sample taken after the c-th rising edge (c=1: accept edge).
  // rd_at/restart_at/flush_at: cycle after whose sample that input is driven
  // (0 = never). gap: spend one idle cycle afterwards.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                       input int rd_at, input int restart_at, input int flush_at,
                       input bit gap);
    logic [63:0] prod;
    int          lat;
    bit          flushed;
    bit          exp_busy;
    if (sgn) prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    else     prod = {32'd0, a} * {32'd0, b};
    lat   = sgn ? 34 : 33;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
`ifdef MULT_SIGNED_EN
    signed_op = sgn;
`endif
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      flushed  = (flush_at > 0) && (c > flush_at);
      exp_busy = !flushed && (c < lat);
      check($sformatf("busy c%0d", c), 64'(busy), 64'(exp_busy));
      check($sformatf("done c%0d", c), 64'(done), 64'(!flushed && (c == lat)));
      check($sformatf("stall c%0d", c), 64'(stall), 64'(exp_busy && (rd_hilo || start)));
      if (c == 2) begin
        check("hi hold", 64'(hi), 64'(exp_hi));
        check("lo hold", 64'(lo), 64'(exp_lo));
      end
      if (c == lat) begin
        if (!flushed) {exp_hi, exp_lo} = prod;
        check($sformatf("hi %h*%h", a, b), 64'(hi), 64'(exp_hi));
        check($sformatf("lo %h*%h", a, b), 64'(lo), 64'(exp_lo));
      end
      rd_hilo = (rd_at > 0) && (c >= rd_at);
      start   = (c == restart_at);
      flush   = (c == flush_at);
    end
    rd_hilo = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    if (gap) begin
      @(negedge clk);
      check("done after pulse", 64'(done), 64'd0);
      check("busy after pulse", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int  rd_at, re_at, fl_at;
    bit  sgn;
    logic [31:0] ra, rb;

    // Reset state, and MFHI/MFLO in IDLE must not stall.
    @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    rd_hilo = 1'b1;
    #1;
    check("rst stall", 64'(stall), 64'd0);
    rd_hilo = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(32'd7, 32'd6, 1'b0, 0, 0, 0, 1'b1);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0, 1'b1);
    // MFHI/MFLO from cycle 5 stalls until done; second start at 10 ignored.
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 5, 10, 0, 1'b0);
    do_op(32'd3, 32'd4, 1'b0, 0, 0, 0, 1'b1);
    // Flush at iteration 10: hi=0, lo=0xC retained, done never pulses.
    do_op(32'd9, 32'd9, 1'b0, 0, 0, 11, 1'b1);
    check("flush keeps hi", 64'(hi), 64'h0);
    check("flush keeps lo", 64'(lo), 64'hC);
    // Flush coinciding with the final iteration must not publish a result.
    do_op(32'hDEAD_BEEF, 32'h0000_1001, 1'b0, 0, 0, 32, 1'b1);

    // Start with a same-cycle flush in IDLE is dropped.
    op_a  = 32'd5;
    op_b  = 32'd5;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush drops start busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("flush drops start busy2", 64'(busy), 64'd0);
    check("flush idle hi", 64'(hi), 64'(exp_hi));
    check("flush idle lo", 64'(lo), 64'(exp_lo));

`ifdef MULT_SIGNED_EN
    do_op(-32'sd3, 32'd5, 1'b1, 0, 0, 0, 1'b1);
    do_op(-32'sd3, 32'd5, 1'b0, 0, 0, 0, 1'b1);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, 0, 1'b0);
`endif

    // Randomized operations, some back-to-back from DONE.
    for (int k = 0; k < 8; k++) begin
      ra = $urandom;
      rb = (k == 3) ? 32'd0 : $urandom;
`ifdef MULT_SIGNED_EN
      sgn = 1'($urandom_range(0, 1));
`else
      sgn = 1'b0;
`endif
      rd_at = int'($urandom_range(0, 40));
      re_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : 0;
      fl_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
      if ((fl_at > 0) && (re_at > fl_at)) re_at = 0;
      do_op(ra, rb, sgn, rd_at, re_at, fl_at, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-RUN clears everything at once.
    @(negedge clk);
    op_a  = 32'h0001_0003;
    op_b  = 32'h0000_0077;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy || done) begin
        check("post-reset idle", 64'({busy, done}), 64'd0);
        break;
      end
    end
    check("post-reset busy", 64'(busy), 64'd0);
    check("post-reset lo", 64'(lo), 64'd0);
    do_op(32'd11, 32'd13, 1'b0, 0, 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_mult_seq_ctrl
`default_nettype wire
